// File: rtl/trap_prio_unit.sv
// Sticky trap-request capture with masked priority encode and a held trap-type code.
// The held code stays put until it is acknowledged.
module trap_prio_unit #(
    parameter int unsigned N_TRAPS = 6,
    parameter int unsigned CODE_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_TRAPS-1:0] trap_req,
    input  logic [N_TRAPS-1:0] trap_mask,
    input  logic               en_traps,
    input  logic               capture,
    input  logic               ack,
    output logic [CODE_W-1:0]  tt_code,
    output logic               tt_valid,
    output logic [N_TRAPS-1:0] pending,
    output logic               pending_any
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [N_TRAPS-1:0]   pending_q, pending_d;
    logic [N_TRAPS-1:0]   eligible;
    logic [N_TRAPS-1:0]   clr;
    logic [CODE_W-1:0]    tt_code_q, tt_code_d;
    logic [CODE_W-1:0]    prio_code;
    logic                 eligible_any;

    assign eligible     = pending_q & trap_mask;
    assign eligible_any = |eligible;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        prio_code = '0;
        for (int i = int'(N_TRAPS) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                prio_code = CODE_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tt_code_d = tt_code_q;
        clr       = '0;
        case (state_q)
            IDLE: begin
                if (capture && en_traps && eligible_any) begin
                    tt_code_d = prio_code;
                    state_d   = HELD;
                end
            end
            HELD: begin
                if (ack) begin
                    clr     = N_TRAPS'(1) << tt_code_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new request on the acknowledged bit re-arms it.
        pending_d = (pending_q & ~clr) | trap_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tt_code_q <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            tt_code_q <= tt_code_d;
            pending_q <= pending_d;
        end
    end

    assign tt_code     = tt_code_q;
    assign tt_valid    = (state_q == HELD);
    assign pending     = pending_q;
    assign pending_any = eligible_any;

endmodule

// File: tb/tb_trap_prio_unit.sv
// Randomized and directed bench for trap_prio_unit at 6 and 12 trap lines,
// checked against a cycle-level behavioural model.
module tb_trap_prio_unit;

    localparam int unsigned NA = 6;
    localparam int unsigned CA = 3;
    localparam int unsigned NB = 12;
    localparam int unsigned CB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          ra, ea, ca, ka;
    logic [NA-1:0] qa, ma;
    logic [CA-1:0] a_tt_code;
    logic          a_tt_valid, a_pending_any;
    logic [NA-1:0] a_pending;

    logic          rb, eb, cb, kb;
    logic [NB-1:0] qb, mb;
    logic [CB-1:0] b_tt_code;
    logic          b_tt_valid, b_pending_any;
    logic [NB-1:0] b_pending;

    trap_prio_unit #(.N_TRAPS(NA), .CODE_W(CA)) u_a (
        .clk(clk), .reset(ra), .trap_req(qa), .trap_mask(ma), .en_traps(ea),
        .capture(ca), .ack(ka), .tt_code(a_tt_code), .tt_valid(a_tt_valid),
        .pending(a_pending), .pending_any(a_pending_any)
    );

    trap_prio_unit #(.N_TRAPS(NB), .CODE_W(CB)) u_b (
        .clk(clk), .reset(rb), .trap_req(qb), .trap_mask(mb), .en_traps(eb),
        .capture(cb), .ack(kb), .tt_code(b_tt_code), .tt_valid(b_tt_valid),
        .pending(b_pending), .pending_any(b_pending_any)
    );

    typedef struct {
        logic [11:0] pend;
        int          code;
        bit          valid;
    } mstate_t;

    mstate_t sa, sb;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the trap unit described as plain rules over a bit vector.
    function automatic mstate_t model_step(input mstate_t s, input bit rst,
                                           input logic [11:0] req, input logic [11:0] mask,
                                           input bit en, input bit cap, input bit ack, input int n);
        mstate_t     r;
        logic [11:0] elig;
        int          low;
        r = s;
        if (rst) begin
            r.pend  = '0;
            r.code  = 0;
            r.valid = 1'b0;
            return r;
        end
        elig = s.pend & mask;
        low  = -1;
        for (int i = 0; i < n; i++) if (elig[i] && low < 0) low = i;
        if (s.valid) begin
            if (ack) begin
                r.pend[s.code] = 1'b0;
                r.valid        = 1'b0;
            end
        end else if (cap && en && low >= 0) begin
            r.code  = low;
            r.valid = 1'b1;
        end
        r.pend = r.pend | req;
        return r;
    endfunction

    task automatic compare();
        check("a.tt_code",     32'(a_tt_code),     32'(sa.code));
        check("a.tt_valid",    32'(a_tt_valid),    32'(sa.valid));
        check("a.pending",     32'(a_pending),     32'(sa.pend[NA-1:0]));
        check("a.pending_any", 32'(a_pending_any), 32'(|(sa.pend[NA-1:0] & ma)));
        check("b.tt_code",     32'(b_tt_code),     32'(sb.code));
        check("b.tt_valid",    32'(b_tt_valid),    32'(sb.valid));
        check("b.pending",     32'(b_pending),     32'(sb.pend));
        check("b.pending_any", 32'(b_pending_any), 32'(|(sb.pend & mb)));
    endtask

    // Inputs are already set (at a negedge); advance one edge and compare.
    task automatic tick();
        sa = model_step(sa, ra, {6'b0, qa}, {6'b0, ma}, ea, ca, ka, NA);
        sb = model_step(sb, rb, qb, mb, eb, cb, kb, NB);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        ra = 0; qa = '0; ma = '1; ea = 1; ca = 0; ka = 0;
        rb = 0; qb = '0; mb = '1; eb = 1; cb = 0; kb = 0;
    endtask

    initial begin
        sa = '{pend: '0, code: 0, valid: 1'b0};
        sb = '{pend: '0, code: 0, valid: 1'b0};
        idle_inputs();
        ra = 1; rb = 1;
        tick();
        check("reset.a_code",  32'(a_tt_code),  32'd0);
        check("reset.a_valid", 32'(a_tt_valid), 32'd0);
        check("reset.a_pend",  32'(a_pending),  32'd0);
        check("reset.b_pend",  32'(b_pending),  32'd0);
        idle_inputs();

        // Single request at bit 3, capture, ack.
        qa = 6'b001000; tick(); qa = '0;
        ca = 1; tick(); ca = 0;
        check("t1.code",  32'(a_tt_code),  32'd3);
        check("t1.valid", 32'(a_tt_valid), 32'd1);
        ka = 1; tick(); ka = 0;
        check("t1.ack_valid", 32'(a_tt_valid), 32'd0);
        check("t1.ack_pend",  32'(a_pending),  32'd0);

        // Two pending, drained in priority order.
        qa = 6'b100010; tick(); qa = '0;
        ca = 1; tick(); ca = 0;
        check("t2.code1", 32'(a_tt_code), 32'd1);
        ka = 1; tick(); ka = 0;
        check("t2.pend1", 32'(a_pending), 32'b100000);
        ca = 1; tick(); ca = 0;
        check("t2.code5", 32'(a_tt_code), 32'd5);
        ka = 1; tick(); ka = 0;
        check("t2.pend0", 32'(a_pending), 32'd0);
        ca = 1; tick(); ca = 0;
        check("t2.empty_valid", 32'(a_tt_valid), 32'd0);
        check("t2.empty_code",  32'(a_tt_code),  32'd5);

        // Masked bit skipped; en_traps low blocks capture.
        qa = 6'b000110; ma = 6'b111011; tick(); qa = '0;
        ca = 1; tick(); ca = 0;
        check("t3.code", 32'(a_tt_code), 32'd1);
        ka = 1; tick(); ka = 0;
        ea = 0; ca = 1; tick(); ca = 0;
        check("t3.en_off_valid", 32'(a_tt_valid), 32'd0);
        ea = 1; ma = '1;

        // Held code frozen; set wins over ack clear; reset while held.
        ra = 1; tick(); ra = 0;
        qa = 6'b001000; tick(); qa = '0;
        ca = 1; tick(); ca = 0;
        ca = 1; ma = '0; qa = 6'b000001; tick();
        ca = 0; ma = '1; qa = '0;
        check("t4.held_code",  32'(a_tt_code),  32'd3);
        check("t4.held_valid", 32'(a_tt_valid), 32'd1);
        ka = 1; qa = 6'b001000; tick(); ka = 0; qa = '0;
        check("t4.set_wins", 32'(a_pending[3]), 32'd1);
        ca = 1; tick(); ca = 0;
        check("t4.recap", 32'(a_tt_code), 32'd0);
        ra = 1; tick(); ra = 0;
        check("t4.rst_code",  32'(a_tt_code),  32'd0);
        check("t4.rst_valid", 32'(a_tt_valid), 32'd0);
        check("t4.rst_pend",  32'(a_pending),  32'd0);

        // Wide instance: top index and simultaneous requests.
        qb = 12'b1000_0000_0000; tick(); qb = '0;
        cb = 1; tick(); cb = 0;
        check("t5.code11", 32'(b_tt_code), 32'd11);
        kb = 1; tick(); kb = 0;
        qb = 12'b0100_0001_0000; tick(); qb = '0;
        cb = 1; tick(); cb = 0;
        check("t5.code4", 32'(b_tt_code), 32'd4);
        kb = 1; tick(); kb = 0;

        // Randomized traffic on both instances.
        for (int c = 0; c < 2000; c++) begin
            ra = ($urandom_range(99) == 0);
            rb = ($urandom_range(99) == 0);
            for (int i = 0; i < int'(NA); i++) qa[i] = ($urandom_range(7) == 0);
            for (int i = 0; i < int'(NB); i++) qb[i] = ($urandom_range(9) == 0);
            ma = ($urandom_range(3) == 0) ? NA'($urandom) : '1;
            mb = ($urandom_range(3) == 0) ? NB'($urandom) : '1;
            ea = ($urandom_range(7) != 0);
            eb = ($urandom_range(7) != 0);
            ca = ($urandom_range(1) == 0);
            cb = ($urandom_range(1) == 0);
            ka = ($urandom_range(2) == 0);
            kb = ($urandom_range(2) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_prio_unit.md
# trap_prio_unit

Parametrised trap-type capture unit for the SPARC datapath trap path. It records incoming trap requests in a sticky pending register and, on a capture strobe, priority-encodes the highest-priority enabled request into a trap-type code. The code is held until control acknowledges it. It extends the 6-bit combinational tt encoder with configurable width, per-trap masking, a global trap-enable, sticky pending state and an acknowledge handshake.

## Interface
Parameters:
- N_TRAPS, 6, number of trap request lines; index 0 is highest priority.
- CODE_W, 3, trap-type code width; must satisfy 2^CODE_W >= N_TRAPS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- trap_req  in  N_TRAPS  per-trap request; a 1 in any cycle sets the matching pending bit.
- trap_mask  in  N_TRAPS  per-trap enable; 1 = eligible for capture. Does not affect pending.
- en_traps  in  1  global trap enable (PSR.ET equivalent); 0 blocks capture.
- capture  in  1  capture strobe, sampled every cycle.
- ack  in  1  consumer has taken the held code.
- tt_code  out  CODE_W  registered index of the captured trap.
- tt_valid  out  1  tt_code holds an unacknowledged trap.
- pending  out  N_TRAPS  registered sticky pending vector.
- pending_any  out  1  OR of (pending & trap_mask), registered-path combinational.

## Operation
- Reset: pending=0, tt_code=0, tt_valid=0, FSM=IDLE. Reset overrides every other input in the same cycle.
- Pending update each edge: pending_next = (pending & ~clr) | trap_req.
  - clr is the one-hot bit of tt_code when an ack is accepted, otherwise 0.
  - A set wins over a clear on the same bit in the same cycle.
- eligible = pending & trap_mask, computed from registered pending. trap_req from the current cycle is not yet visible.
- Priority: the lowest set index of eligible, zero-extended to CODE_W bits.
- FSM IDLE:
  - If capture=1, en_traps=1 and eligible!=0: tt_code <= encoded index, tt_valid <= 1, go to HELD.
  - Otherwise remain in IDLE, tt_code retains its last value, tt_valid stays 0.
- FSM HELD:
  - tt_code and tt_valid are frozen. capture is ignored. Changes to mask or en_traps do not alter the held code.
  - If ack=1: clear pending[tt_code], tt_valid <= 0, go to IDLE.
  - ack in IDLE has no effect.
- The held trap's pending bit stays set until ack. It is therefore visible on the pending output while held.
- Masked pending bits persist indefinitely and become eligible as soon as their mask bit rises.

## Timing
- trap_req at edge t: pending bit visible after edge t. Earliest capture is in cycle t+1.
- capture accepted at edge t: tt_valid=1 and tt_code valid after edge t (1-cycle latency).
- ack accepted at edge t: tt_valid=0 after edge t. A new capture can be accepted at edge t+1 at the earliest, not in the same cycle as ack.
- capture held high continuously: captures once per IDLE visit, i.e. at most every 2 cycles under an immediate ack.
- Reset asserted mid-HELD: next edge returns to IDLE with all outputs 0. A pending trap is lost.
- Out-of-range encodings cannot occur. Bits of tt_code above clog2(N_TRAPS) are always 0.

## Test plan
- Reset, then trap_req=6'b001000 for 1 cycle, mask=6'b111111, en_traps=1, capture pulsed 1 cycle -> tt_code=3, tt_valid=1 one cycle later; ack -> tt_valid=0, pending=0.
- pending=6'b100010, capture -> tt_code=1; ack -> pending=6'b100000; capture -> tt_code=5; ack -> pending=0.
- pending=6'b000110, mask=6'b111011, capture -> tt_code=1 (bit 2 masked); en_traps=0 with capture -> no capture, tt_valid stays 0.
- In HELD with tt_code=3: pulse capture, change mask to 0, assert trap_req bit 0 -> tt_code stays 3. ack with trap_req bit 3 high in the same cycle -> pending bit 3 remains set.
- capture with eligible=0 after a prior capture of code 5 -> tt_valid=0, tt_code still 5. Reset asserted while HELD -> tt_code=0, tt_valid=0, pending=0 next cycle.
- N_TRAPS=12, CODE_W=4: trap_req=12'b1000_0000_0000, capture -> tt_code=11. Simultaneous requests 12'b0100_0001_0000 -> tt_code=4.
